alu_issuer: RTL

- Initiator side of the ALU strobe interface: accepts a decoded ALU request on a valid/ready handshake, translates it to the one-hot command word, drives data1/data2 and ALUenable with correct setup/strobe/settle timing, captures ALUresult/ALUzero, and returns a tagged response on a second valid/ready handshake.
- Sits between the control/decode stage and the ALU. It guarantees the ALU only ever sees clean, stable-operand rising edges on ALUenable.

---
 rtl/alu_issuer_pkg.sv | 31 +++
 rtl/alu_issuer_cmd_encode.sv | 27 ++
 rtl/alu_issuer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU strobe-interface issuer: op codes, one-hot
// command words, the illegal-op result marker and the issuer FSM states.
package alu_issuer_pkg;

  localparam logic [2:0] OP_SUB = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SL  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam logic [5:0] CMD_SUB = 6'b000001;
  localparam logic [5:0] CMD_ADD = 6'b000010;
  localparam logic [5:0] CMD_SL  = 6'b000100;
  localparam logic [5:0] CMD_XOR = 6'b001000;
  localparam logic [5:0] CMD_OR  = 6'b010000;
  localparam logic [5:0] CMD_AND = 6'b100000;

  localparam logic [31:0] ILLEGAL_RESULT = 32'h1111_1111;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    SETTLE,
    RESP
  } state_t;

endpackage

// File: rtl/alu_issuer_cmd_encode.sv
// Translates a 3-bit decoded ALU op into the one-hot ALU command word and
// flags whether the op is one the ALU can execute.
module alu_cmd_encode
  import alu_issuer_pkg::*;
(
  input  logic [2:0] i_op,
  output logic [5:0] o_cmd,
  output logic       o_is_legal
);

  // BEQ is carried out as a subtraction; the branch decision is the zero flag.
  always_comb begin
    o_cmd      = 6'b000000;
    o_is_legal = 1'b1;
    case (i_op)
      OP_SUB:  o_cmd = CMD_SUB;
      OP_ADD:  o_cmd = CMD_ADD;
      OP_SL:   o_cmd = CMD_SL;
      OP_XOR:  o_cmd = CMD_XOR;
      OP_OR:   o_cmd = CMD_OR;
      OP_AND:  o_cmd = CMD_AND;
      OP_BEQ:  o_cmd = CMD_SUB;
      default: o_is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issuer.sv
// Initiator side of the ALU strobe interface: takes one request at a time,
// strobes the ALU with stable operands, and returns a tagged response.
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int TAG_W         = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             ALUenable,
  output logic [5:0]       command,
  output logic [31:0]      data1,
  output logic [31:0]      data2,
  input  logic [31:0]      ALUresult,
  input  logic             ALUzero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t r_state;
  state_t w_next;

  logic             r_req_ready;
  logic             r_alu_enable;
  logic [5:0]       r_command;
  logic [31:0]      r_data1;
  logic [31:0]      r_data2;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_taken;
  logic             r_rsp_illegal;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [3:0]       r_count;
  logic             r_is_beq;

  logic [5:0] w_cmd;
  logic       w_legal;
  logic       w_accept;
  logic       w_sample;
  logic       w_rsp_done;

  alu_cmd_encode u_encode (
    .i_op      (req_op),
    .o_cmd     (w_cmd),
    .o_is_legal(w_legal)
  );

  assign w_accept   = req_valid && r_req_ready && (r_state == IDLE);
  assign w_sample   = (r_state == SETTLE) && (r_count == 4'd1);
  assign w_rsp_done = (r_state == RESP) && r_rsp_valid && rsp_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? SETUP : RESP;
      SETUP:   w_next = FIRE;
      FIRE:    w_next = SETTLE;
      SETTLE:  if (w_sample) w_next = RESP;
      RESP:    if (w_rsp_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Handshake outputs use the registered valid so a response is never shown
  // for a cycle after the consumer has already taken it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready  <= 1'b0;
      r_alu_enable <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_count      <= 4'd0;
    end else begin
      r_req_ready  <= (w_next == IDLE);
      r_alu_enable <= (r_state == FIRE);
      r_rsp_valid  <= (r_state == RESP) && !w_rsp_done;
      if (r_state == FIRE)        r_count <= SETTLE_LOAD;
      else if (r_state == SETTLE) r_count <= r_count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_command     <= 6'b000000;
      r_data1       <= 32'd0;
      r_data2       <= 32'd0;
      r_rsp_result  <= 32'd0;
      r_rsp_zero    <= 1'b0;
      r_rsp_taken   <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_tag     <= '0;
      r_is_beq      <= 1'b0;
    end else if (w_accept) begin
      r_command <= w_cmd;
      r_data1   <= req_a;
      r_data2   <= req_b;
      r_rsp_tag <= req_tag;
      r_is_beq  <= (req_op == OP_BEQ);
      if (!w_legal) begin
        r_rsp_result  <= ILLEGAL_RESULT;
        r_rsp_zero    <= 1'b0;
        r_rsp_taken   <= 1'b0;
        r_rsp_illegal <= 1'b1;
      end
    end else if (w_sample) begin
      r_rsp_result  <= ALUresult;
      r_rsp_zero    <= ALUzero;
      r_rsp_taken   <= r_is_beq && ALUzero;
      r_rsp_illegal <= 1'b0;
    end
  end

  assign req_ready   = r_req_ready;
  assign ALUenable   = r_alu_enable;
  assign command     = r_command;
  assign data1       = r_data1;
  assign data2       = r_data2;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_taken   = r_rsp_taken;
  assign rsp_illegal = r_rsp_illegal;
  assign rsp_tag     = r_rsp_tag;

endmodule
